mcd_cdd_link: RTL
=================

// Module: mcd_cdd_link
// PURPOSE
//  MCU-side responder for the Mega-CD CDD command/status channel.
//  - Captures the 10-nibble command written by the host (sub-CPU) and exposes it to the MCU as PI-bus reads.
//  - Holds the 10-nibble response the MCU writes over the PI bus.
//  - On the response-ack strobe, waits the configured phase, then publishes the response to the host and raises the CDD IRQ.
//  - Sits beside the MCD PI write decoder and consumes its rack strobe and phase config.
// PARAMETERS
//  PHA_DEF  350  delay in clk cycles used when cfg_pha == 0
//  PHA_W    12   width of cfg_pha and the delay counter
// PORTS
//  clk           in   1      system clock; sole clock
//  rst_n         in   1      reset, asynchronous, active-low
//  pi_ce         in   1      MCD region chip enable
//  pi_addr       in   16     PI address
//  pi_we_sync    in   1      one-cycle PI write strobe
//  pi_oe_sync    in   1      one-cycle PI read strobe
//  pi_dato       in   8      PI write data (MCU->FPGA)
//  pi_dati       out  8      PI read data (FPGA->MCU), registered
//  mcd_rack      in   1      one-cycle response-ack strobe from decoder
//  cfg_pha       in   PHA_W  response->IRQ delay, cycles
//  host_cmd_we   in   1      host command nibble write strobe
//  host_cmd_addr in   4      command nibble index 0..9
//  host_cmd_dat  in   4      command nibble
//  host_cmd_go   in   1      one-cycle "command complete" strobe
//  host_st_addr  in   4      status nibble index 0..9
//  host_st_dat   out  4      status nibble, combinational from published buffer
//  host_irq_ack  in   1      one-cycle host IRQ acknowledge
//  cdd_irq       out  1      CDD interrupt to host, level
//  cmd_pend      out  1      command waiting for MCU
// BEHAVIOUR
//  Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.
//  Reset values: state IDLE, cdd_irq=0, cmd_pend=0, pi_dati=0, ovf=0.
//    All buffers (cmd_wr, cmd_sh, resp, stat) reset to 0; delay counter = 0.
//  Host writes: host_cmd_we stores host_cmd_dat into cmd_wr[host_cmd_addr].
//    Indices 10..15 are ignored.
//  MCU reads, pi_ce=1 with pi_addr 0x8000..0x8004, byte n:
//    returns {cmd_sh[2n], cmd_sh[2n+1]}, even nibble in [7:4].
//  MCU status read at 0x8005: returns {5'd0, ovf, busy, cmd_pend}; busy = state is DELAY or IRQ.
//    pi_oe_sync on 0x8005 clears ovf the following cycle.
//  Other addresses read 0x00. pi_dati updates on every clk from the current pi_addr (1-cycle latency).
//  MCU writes: pi_we_sync & pi_ce at 0x8000..0x8004 stores pi_dato into resp byte n, same nibble order.
//    Allowed in any state.
//  FSM:
//    IDLE : host_cmd_go -> copy cmd_wr into cmd_sh, cmd_pend=1, go to PEND.
//    PEND : host_cmd_go -> recopy cmd_sh and set ovf; stay in PEND.
//           mcd_rack -> cmd_pend=0, load counter with eff_pha, go to DELAY.
//    DELAY: counter decrements each cycle; at 0 copy resp into stat, cdd_irq=1, go to IRQ.
//           mcd_rack at T => cdd_irq first high at T+eff_pha+1.
//    IRQ  : host_irq_ack -> cdd_irq=0, go to IDLE.
//    eff_pha = (cfg_pha==0) ? PHA_DEF : cfg_pha, sampled only when the counter loads.
//  Boundaries:
//    host_cmd_go in DELAY/IRQ: dropped, ovf=1.
//    mcd_rack in IDLE/DELAY/IRQ: ignored.
//    host_cmd_go and mcd_rack in the same PEND cycle: rack wins, go dropped, ovf=1.
//    host_cmd_go and host_irq_ack in the same IRQ cycle: ack taken, go dropped, ovf=1.
//    cfg_pha changes during DELAY: no effect on the running count.
//    host_cmd_we in the same cycle as host_cmd_go: the copy sees the pre-write nibble.
//    rst_n low mid-operation: immediately returns to reset values; cdd_irq drops asynchronously.
// TESTING
//  1. Host writes nibbles 1..A, go -> cmd_pend=1; MCU reads 0x8000..0x8004 -> 0x12,0x34,0x56,0x78,0x9A.
//  2. MCU writes 0x8000..0x8004 = F0,E1,D2,C3,B4; cfg_pha=5; rack at T
//     -> cdd_irq rises at T+6; host_st_dat[0..9] = F,0,E,1,D,2,C,3,B,4.
//  3. cfg_pha=0, rack -> cdd_irq at T+351; host_irq_ack -> cdd_irq=0 next cycle, state IDLE.
//  4. go in DELAY -> status read 0x8005 = 0x06; next status read = 0x02.
//  5. go and rack in the same PEND cycle -> DELAY entered, ovf=1, cmd_pend=0.
//  6. rst_n pulsed low during DELAY -> cdd_irq=0, pi_dati=0; a later rack without go is ignored.

Source files
------------

// File: rtl/mcd_cdd_link.sv
// MCU-side responder for the Mega-CD CDD command/status channel.
// Buffers the host command for PI-bus reads and publishes the MCU response with a delayed IRQ.
module mcd_cdd_link #(
   parameter int unsigned PHA_DEF = 350,
   parameter int unsigned PHA_W   = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pi_ce,
   input  logic [15:0]      pi_addr,
   input  logic             pi_we_sync,
   input  logic             pi_oe_sync,
   input  logic [7:0]       pi_dato,
   output logic [7:0]       pi_dati,
   input  logic             mcd_rack,
   input  logic [PHA_W-1:0] cfg_pha,
   input  logic             host_cmd_we,
   input  logic [3:0]       host_cmd_addr,
   input  logic [3:0]       host_cmd_dat,
   input  logic             host_cmd_go,
   input  logic [3:0]       host_st_addr,
   output logic [3:0]       host_st_dat,
   input  logic             host_irq_ack,
   output logic             cdd_irq,
   output logic             cmd_pend
);

   typedef enum logic [1:0] {S_IDLE, S_PEND, S_DELAY, S_IRQ} state_t;

   state_t           state_q, state_d;
   logic [PHA_W-1:0] cnt_q, cnt_d;
   logic             irq_q, irq_d;
   logic             pend_q, pend_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       pi_dati_q, pi_dati_d;

   logic [3:0] cmd_wr_q [10];
   logic [3:0] cmd_sh_q [10];
   logic [3:0] resp_q   [10];
   logic [3:0] stat_q   [10];

   logic             copy_cmd, copy_resp, ovf_set;
   logic             busy, pi_win, pi_st;
   logic [3:0]       nib_e, nib_o;
   logic [PHA_W-1:0] eff_pha;

   assign eff_pha = (cfg_pha == '0) ? PHA_W'(PHA_DEF) : cfg_pha;
   assign busy    = (state_q == S_DELAY) || (state_q == S_IRQ);
   assign pi_win  = pi_ce && (pi_addr[15:3] == 13'h1000) && (pi_addr[2:0] <= 3'd4);
   assign pi_st   = pi_ce && (pi_addr == 16'h8005);
   assign nib_e   = {pi_addr[2:0], 1'b0};
   assign nib_o   = {pi_addr[2:0], 1'b1};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      irq_d     = irq_q;
      pend_d    = pend_q;
      copy_cmd  = 1'b0;
      copy_resp = 1'b0;
      ovf_set   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (host_cmd_go) begin
               copy_cmd = 1'b1;
               pend_d   = 1'b1;
               state_d  = S_PEND;
            end
         end
         S_PEND: begin
            // rack takes priority; a coincident go is counted as an overflow
            if (mcd_rack) begin
               pend_d  = 1'b0;
               cnt_d   = eff_pha;
               state_d = S_DELAY;
               ovf_set = host_cmd_go;
            end else if (host_cmd_go) begin
               copy_cmd = 1'b1;
               ovf_set  = 1'b1;
            end
         end
         S_DELAY: begin
            ovf_set = host_cmd_go;
            if (cnt_q == '0) begin
               copy_resp = 1'b1;
               irq_d     = 1'b1;
               state_d   = S_IRQ;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_IRQ: begin
            ovf_set = host_cmd_go;
            if (host_irq_ack) begin
               irq_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      ovf_d = ovf_q;
      if (ovf_set)
         ovf_d = 1'b1;
      else if (pi_oe_sync && pi_st)
         ovf_d = 1'b0;

      pi_dati_d = '0;
      if (pi_win)
         pi_dati_d = {cmd_sh_q[nib_e], cmd_sh_q[nib_o]};
      else if (pi_st)
         pi_dati_d = {5'd0, ovf_q, busy, pend_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         irq_q     <= 1'b0;
         pend_q    <= 1'b0;
         ovf_q     <= 1'b0;
         pi_dati_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         irq_q     <= irq_d;
         pend_q    <= pend_d;
         ovf_q     <= ovf_d;
         pi_dati_q <= pi_dati_d;
      end
   end

   // copies read the pre-edge buffers, so a same-cycle host write lands after the copy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_wr_q <= '{default: '0};
         cmd_sh_q <= '{default: '0};
         resp_q   <= '{default: '0};
         stat_q   <= '{default: '0};
      end else begin
         if (host_cmd_we && (host_cmd_addr < 4'd10))
            cmd_wr_q[host_cmd_addr] <= host_cmd_dat;
         if (copy_cmd)
            cmd_sh_q <= cmd_wr_q;
         if (pi_we_sync && pi_win) begin
            resp_q[nib_e] <= pi_dato[7:4];
            resp_q[nib_o] <= pi_dato[3:0];
         end
         if (copy_resp)
            stat_q <= resp_q;
      end
   end

   assign pi_dati     = pi_dati_q;
   assign cdd_irq     = irq_q;
   assign cmd_pend    = pend_q;
   assign host_st_dat = (host_st_addr < 4'd10) ? stat_q[host_st_addr] : 4'd0;

endmodule
